// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states, owner id, op and latched command.
package mem_arbiter_pkg;

  typedef logic [31:0] size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic req_id_t;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } op_t;

  typedef struct packed {
    op_t        op;
    size_t      addr;
    size_t      wdata;
    logic [3:0] be;
  } cmd_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin pick between two requesters; a tie goes to the one not granted last.
// Purely combinational, zero latency; no flow control of its own.
module mem_arbiter_rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_grant,
  output logic       grant_valid,
  output req_id_t    grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = 1'b0;
    case (req)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between two held-until-resp requesters, round-robin, with a hang watchdog.
// Grant->strobe 1 cycle, mem_resp->ri_resp 1 cycle; requesters hold read/write until their resp pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_read,
  input  logic        r0_write,
  input  logic [3:0]  r0_byte_enable,
  input  logic [31:0] r0_address,
  input  logic [31:0] r0_wdata,
  output logic        r0_resp,
  output logic [31:0] r0_rdata,
  input  logic        r1_read,
  input  logic        r1_write,
  input  logic [3:0]  r1_byte_enable,
  input  logic [31:0] r1_address,
  input  logic [31:0] r1_wdata,
  output logic        r1_resp,
  output logic [31:0] r1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);

  localparam logic             WDOG_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  req_id_t          last_grant_q, last_grant_d;
  req_id_t          owner_q, owner_d;
  cmd_t             cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  size_t            rdata_q, rdata_d;
  logic             to_q, to_d;

  logic    [1:0] req;
  logic          grant_valid;
  req_id_t       grant_id;
  cmd_t          r0_cmd, r1_cmd;

  assign req = {r1_read | r1_write, r0_read | r0_write};

  // Write wins when a requester raises both strobes.
  assign r0_cmd = '{op: (r0_write ? WR : RD), addr: r0_address, wdata: r0_wdata, be: r0_byte_enable};
  assign r1_cmd = '{op: (r1_write ? WR : RD), addr: r1_address, wdata: r1_wdata, be: r1_byte_enable};

  mem_arbiter_rr_pick u_pick (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cmd_d        = cmd_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    to_d         = to_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_id;
          last_grant_d = grant_id;
          cmd_d        = grant_id ? r1_cmd : r0_cmd;
          cnt_d        = '0;
          to_d         = 1'b0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // A response landing on the watchdog's last cycle still completes normally.
        if (mem_resp) begin
          rdata_d = (cmd_q.op == WR) ? '0 : mem_rdata;
          to_d    = 1'b0;
          state_d = DONE;
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          rdata_d = '0;
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        $fatal(1, "mem_arbiter: illegal state encoding");
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cmd_q        <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cmd_q        <= cmd_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      to_q         <= to_d;
    end
  end

  logic in_issue, in_done;
  assign in_issue = (state_q == ISSUE);
  assign in_done  = (state_q == DONE);

  // Outputs decode straight from reset flops so they drop the instant rst_n falls.
  assign mem_read        = in_issue && (cmd_q.op == RD);
  assign mem_write       = in_issue && (cmd_q.op == WR);
  assign mem_address     = in_issue ? cmd_q.addr : '0;
  assign mem_wdata       = in_issue ? cmd_q.wdata : '0;
  assign mem_byte_enable = (in_issue && (cmd_q.op == WR)) ? cmd_q.be : 4'b0000;

  assign r0_resp     = in_done && (owner_q == 1'b0);
  assign r1_resp     = in_done && (owner_q == 1'b1);
  assign r0_rdata    = r0_resp ? rdata_q : '0;
  assign r1_rdata    = r1_resp ? rdata_q : '0;
  assign timeout_err = in_done && to_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model of arbitration,
// memory latency and the watchdog abort.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_read, r0_write, r1_read, r1_write;
  logic [3:0]  r0_byte_enable, r1_byte_enable;
  logic [31:0] r0_address, r0_wdata, r1_address, r1_wdata;
  logic        r0_resp, r1_resp;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_read, mem_write, mem_resp, timeout_err;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .r0_read         (r0_read),
    .r0_write        (r0_write),
    .r0_byte_enable  (r0_byte_enable),
    .r0_address      (r0_address),
    .r0_wdata        (r0_wdata),
    .r0_resp         (r0_resp),
    .r0_rdata        (r0_rdata),
    .r1_read         (r1_read),
    .r1_write        (r1_write),
    .r1_byte_enable  (r1_byte_enable),
    .r1_address      (r1_address),
    .r1_wdata        (r1_wdata),
    .r1_resp         (r1_resp),
    .r1_rdata        (r1_rdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_read"}, mem_read, 0);
    chk({tag, ".mem_write"}, mem_write, 0);
    chk({tag, ".mem_be"}, mem_byte_enable, 0);
    chk({tag, ".mem_addr"}, mem_address, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".r0_resp"}, r0_resp, 0);
    chk({tag, ".r1_resp"}, r1_resp, 0);
    chk({tag, ".r0_rdata"}, r0_rdata, 0);
    chk({tag, ".r1_rdata"}, r1_rdata, 0);
    chk({tag, ".timeout"}, timeout_err, 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".mem_read"}, mem_read, 0);
    chk({tag, ".mem_write"}, mem_write, 0);
    chk({tag, ".r0_resp"}, r0_resp, 0);
    chk({tag, ".r1_resp"}, r1_resp, 0);
    chk({tag, ".r0_rdata"}, r0_rdata, 0);
    chk({tag, ".r1_rdata"}, r1_rdata, 0);
    chk({tag, ".timeout"}, timeout_err, 0);
  endtask

  task automatic set_req(input bit id, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    if (id == 1'b0) begin
      r0_read = rd; r0_write = wr; r0_address = addr; r0_wdata = wdata; r0_byte_enable = be;
    end else begin
      r1_read = rd; r1_write = wr; r1_address = addr; r1_wdata = wdata; r1_byte_enable = be;
    end
  endtask

  task automatic clr_req(input bit id);
    if (id == 1'b0) begin r0_read = 1'b0; r0_write = 1'b0; end
    else begin r1_read = 1'b0; r1_write = 1'b0; end
  endtask

  // Called at an IDLE negedge with the winner's request already raised. Memory answers in
  // ISSUE cycle 'lat' (0-based); if that is at or beyond TO cycles the watchdog aborts instead.
  // Returns at the IDLE negedge following the owner's resp pulse.
  task automatic serve(input string tag, input bit id, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int lat,
                       input logic [31:0] rd, input bit early_drop);
    bit          to;
    int          n;
    logic [31:0] exp_rd;
    to = (lat >= TO);
    n  = to ? TO : lat + 1;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      chk({tag, ".issue.mem_read"}, mem_read, !wr);
      chk({tag, ".issue.mem_write"}, mem_write, wr);
      chk({tag, ".issue.mem_addr"}, mem_address, addr);
      chk({tag, ".issue.mem_be"}, mem_byte_enable, wr ? be : 4'b0000);
      if (wr) chk({tag, ".issue.mem_wdata"}, mem_wdata, wdata);
      chk({tag, ".issue.r0_resp"}, r0_resp, 0);
      chk({tag, ".issue.r1_resp"}, r1_resp, 0);
      chk({tag, ".issue.timeout"}, timeout_err, 0);
      if (early_drop && k == 0) clr_req(id);
      if (!to && k == lat) begin
        mem_resp  = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_rdata = $urandom;
      end
      @(negedge clk);
      mem_resp = 1'b0;
    end
    exp_rd = (to || wr) ? 32'h0 : rd;
    chk({tag, ".done.mem_read"}, mem_read, 0);
    chk({tag, ".done.mem_write"}, mem_write, 0);
    chk({tag, ".done.r0_resp"}, r0_resp, (id == 1'b0));
    chk({tag, ".done.r1_resp"}, r1_resp, (id == 1'b1));
    chk({tag, ".done.r0_rdata"}, r0_rdata, (id == 1'b0) ? exp_rd : 32'h0);
    chk({tag, ".done.r1_rdata"}, r1_rdata, (id == 1'b1) ? exp_rd : 32'h0);
    chk({tag, ".done.timeout"}, timeout_err, to);
    clr_req(id);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          pend;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mcmd_t;

  mcmd_t model [2];
  bit    last_srv;
  bit    win;
  int    kind;

  initial begin
    rst_n = 1'b1;
    r0_read = 0; r0_write = 0; r0_byte_enable = 0; r0_address = 0; r0_wdata = 0;
    r1_read = 0; r1_write = 0; r1_byte_enable = 0; r1_address = 0; r1_wdata = 0;
    mem_resp = 0; mem_rdata = 0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("in_reset");
    do_reset();

    // Quiet after reset for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_all_zero("idle_after_reset");
    end

    // Single uncontended read, memory answers on the third ISSUE cycle.
    set_req(0, 1, 0, 32'h0000_0040, 32'h0, 4'h0);
    serve("rd40", 0, 0, 32'h0000_0040, 32'h0, 4'h0, 2, 32'hDEAD_BEEF, 0);

    // Contention straight after reset: r0 first, then r1 write, then r0 again.
    do_reset();
    set_req(0, 1, 0, 32'h0000_0100, 32'h0, 4'hF);
    set_req(1, 0, 1, 32'h0000_0080, 32'h1234_5678, 4'b0011);
    serve("cont_r0", 0, 0, 32'h0000_0100, 32'h0, 4'hF, 1, 32'hCAFE_0001, 0);
    serve("cont_r1", 1, 1, 32'h0000_0080, 32'h1234_5678, 4'b0011, 0, 32'hFFFF_FFFF, 0);
    set_req(0, 1, 0, 32'h0000_0200, 32'h0, 4'h0);
    set_req(1, 1, 0, 32'h0000_0300, 32'h0, 4'h0);
    serve("rerace_r0", 0, 0, 32'h0000_0200, 32'h0, 4'h0, 0, 32'h0000_1111, 0);
    serve("rerace_r1", 1, 0, 32'h0000_0300, 32'h0, 4'h0, 1, 32'h0000_2222, 0);

    // Read+write together: the write goes out.
    set_req(1, 1, 1, 32'h0000_0404, 32'hA5A5_5A5A, 4'b1100);
    serve("rw_both", 1, 1, 32'h0000_0404, 32'hA5A5_5A5A, 4'b1100, 1, 32'h0BAD_0BAD, 0);

    // Memory never answers: watchdog aborts, then a normal request still works.
    set_req(0, 1, 0, 32'h0000_0500, 32'h0, 4'h0);
    serve("timeout", 0, 0, 32'h0000_0500, 32'h0, 4'h0, 1000, 32'h0, 0);
    set_req(1, 1, 0, 32'h0000_0600, 32'h0, 4'h0);
    serve("after_to", 1, 0, 32'h0000_0600, 32'h0, 4'h0, 1, 32'h7777_8888, 0);

    // Asynchronous reset during ISSUE, with both requests held through it.
    do_reset();
    set_req(0, 1, 0, 32'h0000_0700, 32'h0, 4'h0);
    serve("pre_rst", 0, 0, 32'h0000_0700, 32'h0, 4'h0, 0, 32'h1, 0);
    set_req(0, 1, 0, 32'h0000_0710, 32'h0, 4'h0);
    set_req(1, 0, 1, 32'h0000_0720, 32'h5555_AAAA, 4'hF);
    @(negedge clk);
    chk("pre_rst.r1_write_issued", mem_write, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst.mem_write", mem_write, 0);
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    serve("post_rst_r0", 0, 0, 32'h0000_0710, 32'h0, 4'h0, 1, 32'h3C3C_3C3C, 0);
    serve("post_rst_r1", 1, 1, 32'h0000_0720, 32'h5555_AAAA, 4'hF, 2, 32'h0, 0);

    // Randomized traffic against the transaction-level model.
    do_reset();
    last_srv = 1'b1;
    model[0].pend = 0;
    model[1].pend = 0;
    for (int it = 0; it < 150; it++) begin
      for (int id = 0; id < 2; id++) begin
        if (!model[id].pend && $urandom_range(0, 2) != 0) begin
          kind = $urandom_range(0, 2);
          model[id].pend  = 1;
          model[id].wr    = (kind != 0);
          model[id].addr  = $urandom;
          model[id].wdata = $urandom;
          model[id].be    = 4'($urandom_range(0, 15));
          set_req(id[0], kind != 1, kind != 0, model[id].addr, model[id].wdata, model[id].be);
        end
      end
      if (!model[0].pend && !model[1].pend) begin
        @(negedge clk);
        chk_quiet("rand_idle");
        continue;
      end
      if (model[0].pend && model[1].pend) win = !last_srv;
      else                                win = model[1].pend;
      last_srv = win;
      serve("rand", win, model[win].wr, model[win].addr, model[win].wdata, model[win].be,
            $urandom_range(0, 5), $urandom, $urandom_range(0, 3) == 0);
      model[win].pend = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
